// File: rtl/bus_arbiter_6502.sv
// Bus arbiter between the 6502 core and a single DMA requester.
// The CPU is stalled through rdy, and the DMA side is granted only once the
// CPU sits halted on a read cycle. Every decision is taken on the phi_en
// strobe that marks a 6502 bus-cycle boundary.
module bus_arbiter_6502 #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic        CLOCK_50,
  input  logic        res,
  input  logic        phi_en,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_dbo,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_ab,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_rw,
  output logic        rdy,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw,
  output logic [7:0]  cpu_dbi,
  output logic        dma_grant,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata
);

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DMA     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             rdy_r, rdy_s;
  logic             grant_r, grant_s;
  logic             ack_r, ack_s;
  logic [7:0]       rdata_r, rdata_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             yield_r, yield_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             burst_end_s;

  // Burst accounting: the transfer being completed now is number count_r + 1.
  always_comb begin
    count_inc_s = count_r + CNT_W'(1);
    burst_end_s = (count_inc_s == CNT_W'(MAX_BURST));
  end

  // State register plus all registered outputs, cleared by the synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (res) begin
      state_r <= ST_CPU;
      rdy_r   <= 1'b1;
      grant_r <= 1'b0;
      ack_r   <= 1'b0;
      rdata_r <= 8'h00;
      count_r <= '0;
      yield_r <= 1'b0;
    end else begin
      state_r <= state_s;
      rdy_r   <= rdy_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      rdata_r <= rdata_s;
      count_r <= count_s;
      yield_r <= yield_s;
    end
  end

  // Next-state logic; dma_ack defaults low so every pulse lasts one clock.
  always_comb begin
    state_s = state_r;
    rdy_s   = rdy_r;
    grant_s = grant_r;
    ack_s   = 1'b0;
    rdata_s = rdata_r;
    count_s = count_r;
    yield_s = yield_r;
    case (state_r)
      ST_CPU: begin
        if (phi_en) begin
          if (yield_r) begin
            // CPU is owed one full cycle after a capped burst.
            yield_s = 1'b0;
          end else if (dma_req) begin
            rdy_s   = 1'b0;
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_CPU;
          end
        end else begin
          state_s = ST_CPU;
        end
      end
      ST_DRAIN: begin
        // An NMOS 6502 ignores rdy on writes, so wait for a read cycle.
        if (phi_en) begin
          if (!dma_req) begin
            rdy_s   = 1'b1;
            state_s = ST_CPU;
          end else if (cpu_rw) begin
            grant_s = 1'b1;
            count_s = '0;
            state_s = ST_DMA;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DMA: begin
        if (phi_en) begin
          if (dma_req) begin
            ack_s   = 1'b1;
            count_s = count_inc_s;
            if (dma_rw) begin
              rdata_s = mem_rdata;
            end else begin
              rdata_s = rdata_r;
            end
            if (burst_end_s) begin
              yield_s = 1'b1;
              state_s = ST_RELEASE;
            end else begin
              state_s = ST_DMA;
            end
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          state_s = ST_DMA;
        end
      end
      ST_RELEASE: begin
        // Grant drops on the first clock here, after the last ack pulse.
        grant_s = 1'b0;
        if (phi_en) begin
          rdy_s   = 1'b1;
          count_s = '0;
          state_s = ST_CPU;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_CPU;
        rdy_s   = 1'b1;
        grant_s = 1'b0;
        count_s = '0;
        yield_s = 1'b0;
      end
    endcase
  end

  // Bus multiplexer driven by the registered grant.
  always_comb begin
    if (grant_r) begin
      mem_ab    = dma_ab;
      mem_wdata = dma_wdata;
      mem_rw    = dma_rw;
    end else begin
      mem_ab    = cpu_ab;
      mem_wdata = cpu_dbo;
      mem_rw    = cpu_rw;
    end
  end

  assign cpu_dbi   = mem_rdata;
  assign rdy       = rdy_r;
  assign dma_grant = grant_r;
  assign dma_ack   = ack_r;
  assign dma_rdata = rdata_r;

endmodule

// File: tb/tb_bus_arbiter_6502.sv
// Directed-vector bench for bus_arbiter_6502, built with MAX_BURST = 4.
module tb_bus_arbiter_6502;

  logic        clk = 1'b0;
  logic        res;
  logic        phi_en;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_dbo;
  logic        cpu_rw;
  logic [7:0]  mem_rdata;
  logic        dma_req;
  logic [15:0] dma_ab;
  logic [7:0]  dma_wdata;
  logic        dma_rw;
  logic        rdy;
  logic [15:0] mem_ab;
  logic [7:0]  mem_wdata;
  logic        mem_rw;
  logic [7:0]  cpu_dbi;
  logic        dma_grant;
  logic        dma_ack;
  logic [7:0]  dma_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  bus_arbiter_6502 #(.MAX_BURST(4), .CNT_W(5)) dut (
    .CLOCK_50(clk), .res(res), .phi_en(phi_en),
    .cpu_ab(cpu_ab), .cpu_dbo(cpu_dbo), .cpu_rw(cpu_rw),
    .mem_rdata(mem_rdata), .dma_req(dma_req), .dma_ab(dma_ab),
    .dma_wdata(dma_wdata), .dma_rw(dma_rw), .rdy(rdy),
    .mem_ab(mem_ab), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .cpu_dbi(cpu_dbi), .dma_grant(dma_grant), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata)
  );

  always #5 clk = ~clk;

  // Vector: inputs applied for one phi_en strobe, outputs expected just
  // after that strobe edge (a) and after the following idle clock (b).
  typedef struct {
    logic        r;
    logic        req;
    logic        drw;
    logic        crw;
    logic [15:0] dab;
    logic [7:0]  rd;
    logic        e_rdy;
    logic        e_ga;
    logic        e_ack;
    logic [7:0]  e_rdata;
    logic        e_gb;
    logic [15:0] e_ab;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Invariants checked every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (dma_grant && rdy) begin
        n_err++;
        $display("FAIL inv_rdy_grant: rdy=%b dma_grant=%b", rdy, dma_grant);
      end
      n_cmp++;
      if (dma_ack && !dma_grant) begin
        n_err++;
        $display("FAIL inv_ack_grant: dma_ack=%b dma_grant=%b", dma_ack, dma_grant);
      end
    end
  end

  initial begin
    logic        s_rdy, s_ga, s_ack, s_gb, s_ackb;
    logic [7:0]  s_rdata, s_dbi, s_wd;
    logic [15:0] s_ab;
    logic        s_rw;

    // res=1, rdy, ga, ack, rdata, gb, ab
    // single DMA read
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h8000,8'h5A, 1'b0,1'b0,1'b0,8'h00,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h8000,8'h5A, 1'b0,1'b1,1'b0,8'h00,1'b1,16'h8000});
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h8000,8'h5A, 1'b0,1'b1,1'b1,8'h5A,1'b1,16'h8000});
    vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b1,16'h8000,8'h5A, 1'b0,1'b1,1'b0,8'h5A,1'b0,16'h1234});
    // request rises as RELEASE completes (yield clear)
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h8000,8'h5A, 1'b1,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    // drain: three CPU write strobes, then a read
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,16'h8001,8'hC3, 1'b0,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,16'h8001,8'hC3, 1'b0,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,16'h8001,8'hC3, 1'b0,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h8001,8'hC3, 1'b0,1'b1,1'b0,8'h5A,1'b1,16'h8001});
    vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b1,16'h8001,8'hC3, 1'b0,1'b1,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b1,16'h8001,8'hC3, 1'b1,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    // burst of 4 writes with request held high
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0200,8'hEE, 1'b0,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0200,8'hEE, 1'b0,1'b1,1'b0,8'h5A,1'b1,16'h0200});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0200,8'hEE, 1'b0,1'b1,1'b1,8'h5A,1'b1,16'h0200});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0201,8'hEE, 1'b0,1'b1,1'b1,8'h5A,1'b1,16'h0201});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0202,8'hEE, 1'b0,1'b1,1'b1,8'h5A,1'b1,16'h0202});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0203,8'hEE, 1'b0,1'b1,1'b1,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0203,8'hEE, 1'b1,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0203,8'hEE, 1'b1,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,16'h0203,8'hEE, 1'b0,1'b0,1'b0,8'h5A,1'b0,16'h1234});
    // re-arbitrated grant, one read, then reset mid-burst
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h4000,8'h3C, 1'b0,1'b1,1'b0,8'h5A,1'b1,16'h4000});
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,16'h4000,8'h3C, 1'b0,1'b1,1'b1,8'h3C,1'b1,16'h4000});
    vq.push_back(vec_t'{1'b1,1'b1,1'b1,1'b1,16'h4000,8'h77, 1'b1,1'b0,1'b0,8'h00,1'b0,16'h1234});
    // request withdrawn while draining
    vq.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,16'h4000,8'h77, 1'b0,1'b0,1'b0,8'h00,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,16'h4000,8'h77, 1'b1,1'b0,1'b0,8'h00,1'b0,16'h1234});
    vq.push_back(vec_t'{1'b0,1'b0,1'b1,1'b1,16'h4000,8'h77, 1'b1,1'b0,1'b0,8'h00,1'b0,16'h1234});

    // Reset held for three clocks.
    res = 1'b1; phi_en = 1'b0; cpu_ab = 16'h1234; cpu_dbo = 8'h11; cpu_rw = 1'b1;
    mem_rdata = 8'h00; dma_req = 1'b0; dma_ab = 16'h0000; dma_wdata = 8'h00; dma_rw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(rdy), 32'h1);
    chk("reset_grant", 32'(dma_grant), 32'h0);
    chk("reset_ack", 32'(dma_ack), 32'h0);
    chk("reset_mem_ab", 32'(mem_ab), 32'h1234);
    chk("reset_rdata", 32'(dma_rdata), 32'h00);
    res = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      res = vq[i].r; dma_req = vq[i].req; dma_rw = vq[i].drw; cpu_rw = vq[i].crw;
      dma_ab = vq[i].dab; dma_wdata = vq[i].dab[7:0] ^ 8'hA5; mem_rdata = vq[i].rd;
      phi_en = 1'b1;
      @(posedge clk); #1;
      s_rdy = rdy; s_ga = dma_grant; s_ack = dma_ack; s_rdata = dma_rdata;
      phi_en = 1'b0; res = 1'b0;
      @(posedge clk); #1;
      s_gb = dma_grant; s_ackb = dma_ack; s_ab = mem_ab; s_dbi = cpu_dbi;
      s_wd = mem_wdata; s_rw = mem_rw;
      chk($sformatf("v%0d_rdy", i), 32'(s_rdy), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d_grant_a", i), 32'(s_ga), 32'(vq[i].e_ga));
      chk($sformatf("v%0d_ack", i), 32'(s_ack), 32'(vq[i].e_ack));
      chk($sformatf("v%0d_rdata", i), 32'(s_rdata), 32'(vq[i].e_rdata));
      chk($sformatf("v%0d_grant_b", i), 32'(s_gb), 32'(vq[i].e_gb));
      chk($sformatf("v%0d_ack_b", i), 32'(s_ackb), 32'h0);
      chk($sformatf("v%0d_mem_ab", i), 32'(s_ab), 32'(vq[i].e_ab));
      chk($sformatf("v%0d_mem_wr", i), {23'h0, s_wd, s_rw},
          vq[i].e_gb ? {23'h0, vq[i].dab[7:0] ^ 8'hA5, vq[i].drw} : {23'h0, 8'h11, vq[i].crw});
      chk($sformatf("v%0d_cpu_dbi", i), 32'(s_dbi), 32'(vq[i].rd));
    end

    // Without a phi_en strobe a pending request must not move rdy.
    dma_req = 1'b1; cpu_rw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("nophi_rdy%0d", k), 32'(rdy), 32'h1);
    end
    phi_en = 1'b1;
    @(posedge clk); #1;
    phi_en = 1'b0;
    chk("phi_rdy_fall", 32'(rdy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_hold_grant", 32'(dma_grant), 32'h0);
    dma_req = 1'b0; phi_en = 1'b1;
    @(posedge clk); #1;
    phi_en = 1'b0;
    chk("withdraw_rdy", 32'(rdy), 32'h1);
    chk("withdraw_grant", 32'(dma_grant), 32'h0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
